// File: rtl/ahb_rr_arbiter_pkg.sv
// Shared AHB-Lite encodings for the round-robin master-port arbiter.
package ahb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BYTE = 3'b000,
    HALF = 3'b001,
    WORD = 3'b010
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_rr_arbiter_if.sv
// AHB-Lite master-port bundle between the arbiter and the slave mux.
interface ahb_rr_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import ahb_rr_arbiter_pkg::*;

  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  htrans_t               HTRANS;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
    output HREADY, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational masked round-robin picker: first unmasked request at or after ptr.
module ahb_rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         mask,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!valid && req[j] && !mask[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Shares one AHB-Lite master port among NUM_REQ single-beat requesters, overlapping
// one requester's address phase with another's data phase.
module ahb_rr_arbiter
  import ahb_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*3-1:0]          req_size,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         rdata,
  ahb_rr_arbiter_if.master              bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic             a_vld, d_vld, err_first;
  logic [IDX_W-1:0] a_id, d_id, rr_ptr;

  logic               pick_vld;
  logic [NUM_REQ-1:0] pick_grant, mask;
  logic [IDX_W-1:0]   pick_idx;

  // Owners of either pipeline stage are excluded so nobody is granted twice at once.
  always_comb begin
    mask = '0;
    if (a_vld) mask[a_id] = 1'b1;
    if (d_vld) mask[d_id] = 1'b1;
  end

  ahb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req),
    .mask  (mask),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    bus.HTRANS = IDLE;
    bus.HADDR  = '0;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = '0;
    bus.HWDATA = '0;
    ack        = '0;
    if (a_vld) begin
      // An ERROR response on the data phase cancels the pending address phase.
      bus.HTRANS = (d_vld && bus.HRESP == HRESP_ERROR) ? IDLE : NONSEQ;
      bus.HADDR  = req_addr[int'(a_id)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.HWRITE = req_write[a_id];
      bus.HSIZE  = req_size[int'(a_id)*3 +: 3];
    end
    if (d_vld) begin
      bus.HWDATA = req_wdata[int'(d_id)*DATA_WIDTH +: DATA_WIDTH];
      if (bus.HREADY) ack[d_id] = 1'b1;
    end
  end

  assign err   = (|ack) && (bus.HRESP == HRESP_ERROR);
  assign rdata = bus.HRDATA;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_vld     <= 1'b0;
      d_vld     <= 1'b0;
      a_id      <= '0;
      d_id      <= '0;
      rr_ptr    <= '0;
      err_first <= 1'b0;
    end else begin
      err_first <= !bus.HREADY && (bus.HRESP == HRESP_ERROR);
      if (bus.HREADY) begin
        if (d_vld && bus.HRESP == HRESP_ERROR) begin
          d_vld <= 1'b0;
        end else begin
          d_vld <= a_vld;
          d_id  <= a_id;
          a_vld <= pick_vld;
          if (pick_vld) begin
            a_id   <= pick_idx;
            rr_ptr <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
      end
    end
  end

  a_err_two_cycle: assert property (@(posedge clk) disable iff (reset)
    (bus.HREADY && bus.HRESP == HRESP_ERROR) |-> err_first);

  a_req_held_addr: assert property (@(posedge clk) disable iff (reset)
    a_vld |-> req[a_id]);

  a_req_held_data: assert property (@(posedge clk) disable iff (reset)
    d_vld |-> req[d_id]);

  a_pick_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(pick_grant) && (pick_vld == (|pick_grant)));

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter with hand-computed expectations.
module tb_ahb_rr_arbiter;
  import ahb_rr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_write;
  logic [N*3-1:0]  req_size;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic            err;
  logic [DW-1:0]   rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] wd);
    req_addr[i*AW +: AW]  = addr;
    req_write[i]          = wr;
    req_size[i*3 +: 3]    = sz;
    req_wdata[i*DW +: DW] = wd;
  endtask

  initial begin
    reset      = 1'b1;
    req        = '0;
    req_addr   = '0;
    req_write  = '0;
    req_size   = '0;
    req_wdata  = '0;
    bus.HREADY = 1'b1;
    bus.HRESP  = HRESP_OKAY;
    bus.HRDATA = '0;

    // Reset state
    nxt(); nxt(); #1;
    chk("rst_htrans", 32'(bus.HTRANS), 32'(IDLE));
    chk("rst_haddr",  bus.HADDR, 32'h0);
    chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
    chk("rst_hsize",  32'(bus.HSIZE), 32'h0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_ack",    32'(ack), 32'h0);
    chk("rst_err",    32'(err), 32'h0);
    reset = 1'b0;

    // Single read by requester 2 on an idle bus
    set_req(2, 32'h0000_0040, 1'b0, WORD, 32'h0);
    req = 4'b0100;
    #1 chk("t1_c0_htrans", 32'(bus.HTRANS), 32'(IDLE));
    nxt(); bus.HRDATA = 32'hDEAD_BEEF;
    #1 chk("t1_c1_htrans", 32'(bus.HTRANS), 32'(NONSEQ));
    chk("t1_c1_haddr",  bus.HADDR, 32'h40);
    chk("t1_c1_hwrite", 32'(bus.HWRITE), 32'h0);
    chk("t1_c1_ack",    32'(ack), 32'h0);
    nxt();
    #1 chk("t1_c2_ack", 32'(ack), 32'b0100);
    chk("t1_c2_rdata",  rdata, 32'hDEAD_BEEF);
    chk("t1_c2_err",    32'(err), 32'h0);
    nxt(); req = '0;
    #1 chk("t1_c3_ack", 32'(ack), 32'h0);
    chk("t1_c3_htrans", 32'(bus.HTRANS), 32'(IDLE));

    // All four write at once right after reset
    reset = 1'b1;
    nxt(); reset = 1'b0;
    set_req(0, 32'h100, 1'b1, WORD, 32'h1111_1111);
    set_req(1, 32'h104, 1'b1, WORD, 32'h2222_2222);
    set_req(2, 32'h108, 1'b1, WORD, 32'h3333_3333);
    set_req(3, 32'h10C, 1'b1, WORD, 32'h4444_4444);
    req = 4'b1111;
    nxt();
    #1 chk("t2_c1_htrans", 32'(bus.HTRANS), 32'(NONSEQ));
    chk("t2_c1_haddr",  bus.HADDR, 32'h100);
    chk("t2_c1_hwrite", 32'(bus.HWRITE), 32'h1);
    chk("t2_c1_hsize",  32'(bus.HSIZE), 32'(WORD));
    nxt();
    #1 chk("t2_c2_ack", 32'(ack), 32'b0001);
    chk("t2_c2_hwdata", bus.HWDATA, 32'h1111_1111);
    chk("t2_c2_haddr",  bus.HADDR, 32'h104);
    nxt(); req = 4'b1110;
    #1 chk("t2_c3_ack", 32'(ack), 32'b0010);
    chk("t2_c3_hwdata", bus.HWDATA, 32'h2222_2222);
    chk("t2_c3_haddr",  bus.HADDR, 32'h108);
    nxt(); req = 4'b1100;
    #1 chk("t2_c4_ack", 32'(ack), 32'b0100);
    chk("t2_c4_hwdata", bus.HWDATA, 32'h3333_3333);
    chk("t2_c4_haddr",  bus.HADDR, 32'h10C);
    nxt(); req = 4'b1000;
    #1 chk("t2_c5_ack", 32'(ack), 32'b1000);
    chk("t2_c5_hwdata", bus.HWDATA, 32'h4444_4444);
    chk("t2_c5_htrans", 32'(bus.HTRANS), 32'(IDLE));
    nxt(); req = '0;
    #1 chk("t2_c6_ack", 32'(ack), 32'h0);

    // Two wait states on requester 1's data phase with requester 3 pending
    nxt();
    set_req(1, 32'h200, 1'b0, WORD, 32'h0);
    set_req(3, 32'h300, 1'b0, WORD, 32'h0);
    req = 4'b1010;
    nxt();
    #1 chk("t3_c1_haddr", bus.HADDR, 32'h200);
    chk("t3_c1_htrans", 32'(bus.HTRANS), 32'(NONSEQ));
    nxt(); bus.HREADY = 1'b0;
    #1 chk("t3_w1_haddr", bus.HADDR, 32'h300);
    chk("t3_w1_htrans", 32'(bus.HTRANS), 32'(NONSEQ));
    chk("t3_w1_ack",    32'(ack), 32'h0);
    nxt();
    #1 chk("t3_w2_haddr", bus.HADDR, 32'h300);
    chk("t3_w2_htrans", 32'(bus.HTRANS), 32'(NONSEQ));
    chk("t3_w2_ack",    32'(ack), 32'h0);
    nxt(); bus.HREADY = 1'b1; bus.HRDATA = 32'h1234_5678;
    #1 chk("t3_rdy_ack", 32'(ack), 32'b0010);
    chk("t3_rdy_rdata",  rdata, 32'h1234_5678);
    chk("t3_rdy_haddr",  bus.HADDR, 32'h300);
    chk("t3_rdy_htrans", 32'(bus.HTRANS), 32'(NONSEQ));
    nxt(); req = 4'b1000; bus.HRDATA = 32'h5555_AAAA;
    #1 chk("t3_c5_ack", 32'(ack), 32'b1000);
    chk("t3_c5_rdata",  rdata, 32'h5555_AAAA);
    chk("t3_c5_htrans", 32'(bus.HTRANS), 32'(IDLE));
    nxt(); req = '0;
    #1 chk("t3_c6_ack", 32'(ack), 32'h0);

    // Two-cycle ERROR on requester 0 with requester 1 pending
    nxt();
    set_req(0, 32'h400, 1'b1, WORD, 32'h0BAD_0BAD);
    set_req(1, 32'h404, 1'b0, WORD, 32'h0);
    req = 4'b0011;
    nxt();
    #1 chk("t4_c1_haddr", bus.HADDR, 32'h400);
    chk("t4_c1_htrans", 32'(bus.HTRANS), 32'(NONSEQ));
    nxt(); bus.HREADY = 1'b0; bus.HRESP = HRESP_ERROR;
    #1 chk("t4_e1_htrans", 32'(bus.HTRANS), 32'(IDLE));
    chk("t4_e1_ack",    32'(ack), 32'h0);
    chk("t4_e1_hwdata", bus.HWDATA, 32'h0BAD_0BAD);
    nxt(); bus.HREADY = 1'b1;
    #1 chk("t4_e2_ack", 32'(ack), 32'b0001);
    chk("t4_e2_err",    32'(err), 32'h1);
    chk("t4_e2_htrans", 32'(bus.HTRANS), 32'(IDLE));
    nxt(); bus.HRESP = HRESP_OKAY; req = 4'b0010;
    #1 chk("t4_re_htrans", 32'(bus.HTRANS), 32'(NONSEQ));
    chk("t4_re_haddr", bus.HADDR, 32'h404);
    chk("t4_re_ack",   32'(ack), 32'h0);
    nxt(); bus.HRDATA = 32'hCAFE_F00D;
    #1 chk("t4_c5_ack", 32'(ack), 32'b0010);
    chk("t4_c5_err",    32'(err), 32'h0);
    chk("t4_c5_rdata",  rdata, 32'hCAFE_F00D);
    nxt(); req = '0;
    #1 chk("t4_c6_htrans", 32'(bus.HTRANS), 32'(IDLE));
    chk("t4_c6_ack", 32'(ack), 32'h0);

    // Fairness: requester 0 keeps requesting, requester 2 arrives after first grant
    nxt();
    set_req(0, 32'h500, 1'b0, WORD, 32'h0);
    req = 4'b0001;
    nxt();
    set_req(2, 32'h520, 1'b0, WORD, 32'h0);
    req = 4'b0101;
    #1 chk("t5_c1_haddr", bus.HADDR, 32'h500);
    nxt();
    #1 chk("t5_c2_ack", 32'(ack), 32'b0001);
    chk("t5_c2_haddr",  bus.HADDR, 32'h520);
    chk("t5_c2_htrans", 32'(bus.HTRANS), 32'(NONSEQ));
    nxt();
    #1 chk("t5_c3_ack", 32'(ack), 32'b0100);
    chk("t5_c3_htrans", 32'(bus.HTRANS), 32'(IDLE));
    nxt(); req = 4'b0001;
    #1 chk("t5_c4_haddr", bus.HADDR, 32'h500);
    chk("t5_c4_htrans", 32'(bus.HTRANS), 32'(NONSEQ));
    nxt();
    #1 chk("t5_c5_ack", 32'(ack), 32'b0001);
    nxt(); req = '0;
    #1 chk("t5_c6_ack", 32'(ack), 32'h0);

    // Asynchronous reset in the middle of a data phase
    nxt();
    set_req(0, 32'h600, 1'b0, WORD, 32'h0);
    set_req(1, 32'h610, 1'b0, WORD, 32'h0);
    req = 4'b0011;
    nxt();
    #1 chk("t6_c1_haddr", bus.HADDR, 32'h610);
    nxt();
    #1 chk("t6_c2_ack", 32'(ack), 32'b0010);
    chk("t6_c2_haddr", bus.HADDR, 32'h600);
    #2 reset = 1'b1;
    #1 chk("t6_rst_htrans", 32'(bus.HTRANS), 32'(IDLE));
    chk("t6_rst_ack",   32'(ack), 32'h0);
    chk("t6_rst_haddr", bus.HADDR, 32'h0);
    nxt(); reset = 1'b0;
    #1 chk("t6_rel_htrans", 32'(bus.HTRANS), 32'(IDLE));
    nxt();
    #1 chk("t6_first_haddr", bus.HADDR, 32'h600);
    chk("t6_first_htrans", 32'(bus.HTRANS), 32'(NONSEQ));
    nxt();
    #1 chk("t6_first_ack", 32'(ack), 32'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
